booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Sequential radix-4 Booth multiplier. It is the datapath and sequencer driven by Booth recode controls: add, sub, shift and nothing.
//  Sits beside the ALU in the execute stage. Accepts a start pulse, iterates WIDTH/2 cycles, then returns the low product word, an overflow flag and a one-cycle ready pulse.
// PARAMETERS
//  WIDTH  32  operand/result width; must be even and >= 4
//  ITER   WIDTH/2  iteration count; derived, do not override
// PORTS
//  clock           in   1      rising-edge clock
//  resetn          in   1      synchronous, active-low reset
//  ctrl_MULT       in   1      start pulse; sampled only when not busy
//  data_operandA   in   WIDTH  multiplicand, signed two's complement
//  data_operandB   in   WIDTH  multiplier, signed; this operand is Booth-recoded
//  data_result     out  WIDTH  low WIDTH bits of the product
//  data_exception  out  1      signed overflow of the WIDTH-bit result
//  data_resultRDY  out  1      one-cycle pulse; result is valid
//  busy            out  1      high while in RUN
//  data_result_hi  out  WIDTH  upper product word; present only with BOOTH_MULT_HI_EN
// BEHAVIOUR
//  Reset (resetn=0 at a clock edge): state=IDLE, count=0, all registers 0.
//   All outputs read 0, including data_result_hi.
//  FSM states IDLE, RUN, DONE.
//   IDLE -> RUN on ctrl_MULT=1.
//   RUN -> DONE when count==ITER-1.
//   DONE -> IDLE, or DONE -> RUN if ctrl_MULT=1 in that cycle.
//  Start: latch M=sext(A) to WIDTH+2 bits. Load P={ (WIDTH+2)'b0, B, 1'b0 }, 2*WIDTH+3 bits. Set count=0.
//  Each RUN cycle, decode triplet P[2:0]:
//   000/111: nothing
//   001/010: +M
//   011: +2M
//   100: -2M
//   101/110: -M
//  Apply the result to the upper WIDTH+2 bits of P, then arithmetic-shift P right by 2. Increment count.
//  Arithmetic: the upper field is WIDTH+2 bits, so +/-2M never overflows it. Subtract is done as add of ~X+1.
//  Product: prod = P[2*WIDTH:1], a 2*WIDTH-bit signed value.
//   data_result = prod[WIDTH-1:0].
//   data_exception = ~(&prod[2W-1:W-1] | ~|prod[2W-1:W-1]), i.e. the upper bits are not all equal to the sign bit.
//  Latency: start sampled at edge t. busy is high for edges t+1..t+ITER. data_resultRDY is high for exactly the cycle after edge t+ITER+1 (17 edges for WIDTH=32).
//  data_result and data_exception update only on entering DONE. They hold until the next DONE or reset; no intermediate values are visible.
//  ctrl_MULT while busy: ignored. The operation in flight is unaffected, and operand changes during RUN have no effect.
//  ctrl_MULT in the DONE cycle: accepted with new operands. data_resultRDY still pulses for the finishing result.
//  resetn=0 mid-RUN: abort at that edge. No data_resultRDY is produced.
//  Operands of 0, -1 and most-negative need no special-case logic; the recode covers them.
// CONFIGURATION
//  BOOTH_MULT_HI_EN defined:
//   data_result_hi port exists and equals prod[2W-1:W], updated and held like data_result.
//   Reset value is 0.
//  BOOTH_MULT_HI_EN undefined:
//   Port absent and the upper-word output register removed.
//   data_exception is unchanged either way.
// TESTING
//  3*5, start pulse at t -> at t+17: data_resultRDY=1, result=15, exc=0, busy low again.
//  -7*6 -> result=0xFFFFFFD6 (-42), exc=0. With HI_EN, hi=0xFFFFFFFF.
//  0x80000000*0xFFFFFFFF -> result=0x80000000, exc=1. With HI_EN, hi=0x00000000.
//  0x00010000*0x00010000 -> result=0, exc=1. With HI_EN, hi=0x00000001.
//  Start 2*3. Pulse ctrl_MULT at cycle 5 with operands 9,9 -> result=6 at t+17, no second RDY.
//   Then start 4*4 in the DONE cycle -> result=16 exactly 17 edges later.
//  Start 100*100, drive resetn=0 at cycle 8 -> no RDY, all outputs 0.
//   Then restart 100*100 -> result=10000.

Source files
------------

// File: rtl/booth_mult_seq.sv
//==============================================================================
// Module      : booth_mult_seq
// Description : Sequential radix-4 Booth multiplier. A start pulse latches the
//               operands, WIDTH/2 iterations retire two multiplier bits each,
//               and the low product word, a signed-overflow flag and a
//               one-cycle ready pulse are returned.
//               Optional macro BOOTH_MULT_HI_EN adds the upper product word
//               output (data_result_hi).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH / 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef BOOTH_MULT_HI_EN
    ,
    output logic [WIDTH-1:0] data_result_hi
`endif
);

    // Partial-product register: accumulator field (WIDTH+2), multiplier
    // (WIDTH) and the implicit Booth bit below it.
    localparam int c_PW    = 2 * WIDTH + 3;
    localparam int c_AW    = WIDTH + 2;
    localparam int c_CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(ITER - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_AW-1:0]    r_mcand;
    logic [c_PW-1:0]    r_prod;

    logic [2:0]          w_triplet;
    logic [c_AW-1:0]     w_upper;
    logic [c_AW-1:0]     w_addend;
    logic [c_AW-1:0]     w_sum;
    logic [c_AW-1:0]     w_twiceM;
    logic [c_PW-1:0]     w_shifted;
    logic [c_PW-1:0]     w_nextProd;
    logic [2*WIDTH-1:0]  w_prodFinal;
    logic [WIDTH:0]      w_signField;
    logic                w_overflow;
    logic                w_start;
    logic                w_lastIter;

    assign w_triplet = r_prod[2:0];
    assign w_upper   = r_prod[c_PW-1 -: c_AW];
    assign w_twiceM  = {r_mcand[c_AW-2:0], 1'b0};

    // Booth recode of the current triplet into the addend for the upper field;
    // subtraction is formed as the two's complement of the magnitude.
    always_comb begin
        w_addend = '0;
        case (w_triplet)
            3'b001, 3'b010: w_addend = r_mcand;
            3'b011:         w_addend = w_twiceM;
            3'b100:         w_addend = ~w_twiceM + c_AW'(1);
            3'b101, 3'b110: w_addend = ~r_mcand + c_AW'(1);
            default:        w_addend = '0;
        endcase
    end

    // The WIDTH+2 upper field holds any +/-2M step without wrapping.
    assign w_sum      = w_upper + w_addend;
    assign w_shifted  = {w_sum, r_prod[WIDTH:0]};
    assign w_nextProd = c_PW'($signed(w_shifted) >>> 2);

    assign w_prodFinal = r_prod[2*WIDTH:1];
    assign w_signField = w_prodFinal[2*WIDTH-1:WIDTH-1];
    assign w_overflow  = ~((&w_signField) | ~(|w_signField));

    assign w_start    = ctrl_MULT && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_lastIter = (r_count == c_LAST_CNT);

    assign busy = (r_state == c_RUN);

    // Sequencer and datapath: load on start, iterate in RUN, ignore starts while busy.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_count <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                c_RUN: begin
                    r_prod  <= w_nextProd;
                    r_count <= r_count + c_CNT_W'(1);
                    if (w_lastIter) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state <= c_RUN;
                        r_count <= '0;
                        r_mcand <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                        r_prod  <= {{c_AW{1'b0}}, data_operandB, 1'b0};
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Result registers: capture the finished product only in the DONE cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (r_state == c_DONE);
            if (r_state == c_DONE) begin
                data_result    <= w_prodFinal[WIDTH-1:0];
                data_exception <= w_overflow;
            end
        end
    end

`ifdef BOOTH_MULT_HI_EN
    // Upper product word, captured alongside the low word.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data_result_hi <= '0;
        end else if (r_state == c_DONE) begin
            data_result_hi <= w_prodFinal[2*WIDTH-1:WIDTH];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
//==============================================================================
// Module      : tb_booth_mult_seq
// Description : Directed self-checking bench for booth_mult_seq (WIDTH=32).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_booth_mult_seq;

    localparam int c_WIDTH = 32;

    logic                clock;
    logic                resetn;
    logic                ctrlMult;
    logic [c_WIDTH-1:0]  opA;
    logic [c_WIDTH-1:0]  opB;
    logic [c_WIDTH-1:0]  result;
    logic                exception;
    logic                resultRdy;
    logic                busy;
`ifdef BOOTH_MULT_HI_EN
    logic [c_WIDTH-1:0]  resultHi;
`endif

    int checks   = 0;
    int failures = 0;

    booth_mult_seq #(.WIDTH(c_WIDTH)) u_dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrlMult),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .data_result    (result),
        .data_exception (exception),
        .data_resultRDY (resultRdy),
        .busy           (busy)
`ifdef BOOTH_MULT_HI_EN
        ,
        .data_result_hi (resultHi)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkHi(input string tag, input logic [31:0] exp);
`ifdef BOOTH_MULT_HI_EN
        checkVal(tag, 64'(resultHi), 64'(exp));
`else
        if (exp === 32'hx) $display("unused %s", tag);
`endif
    endtask

    // Start one multiply, wait for the ready pulse and check it and its latency.
    task automatic doMult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes, input logic expExc, input logic [31:0] expHi);
        int edges;
        @(negedge clock);
        ctrlMult = 1'b1;
        opA      = a;
        opB      = b;
        @(posedge clock);
        #1;
        ctrlMult = 1'b0;
        checkVal({tag, "_busy"}, 64'(busy), 64'd1);
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (resultRdy) break;
        end
        checkVal({tag, "_lat"}, 64'(edges), 64'd17);
        checkVal({tag, "_res"}, 64'(result), 64'(expRes));
        checkVal({tag, "_exc"}, 64'(exception), 64'(expExc));
        checkVal({tag, "_idle"}, 64'(busy), 64'd0);
        checkHi({tag, "_hi"}, expHi);
        @(posedge clock);
        #1;
        checkVal({tag, "_rdyOnce"}, 64'(resultRdy), 64'd0);
    endtask

    initial begin
        int edges;
        int rdyCount;

        resetn   = 1'b0;
        ctrlMult = 1'b0;
        opA      = '0;
        opB      = '0;
        repeat (3) @(posedge clock);
        #1;
        checkVal("rst_res", 64'(result), 64'd0);
        checkVal("rst_exc", 64'(exception), 64'd0);
        checkVal("rst_rdy", 64'(resultRdy), 64'd0);
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkHi("rst_hi", 32'h0);
        resetn = 1'b1;

        doMult("m3x5",   32'd3,          32'd5,          32'd15,         1'b0, 32'h0);
        doMult("mn7x6",  32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0, 32'hFFFFFFFF);
        doMult("mnegx1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, 32'h00000000);
        doMult("m16x16", 32'h00010000,   32'h00010000,   32'h00000000,   1'b1, 32'h00000001);
        doMult("mn1xn1", 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   1'b0, 32'h00000000);
        doMult("mnegsq", 32'h80000000,   32'h80000000,   32'h00000000,   1'b1, 32'h40000000);
        doMult("m0xneg", 32'h00000000,   32'h80000000,   32'h00000000,   1'b0, 32'h00000000);

        // Start during RUN must be ignored; start in the DONE cycle is accepted.
        @(negedge clock);
        ctrlMult = 1'b1;
        opA      = 32'd2;
        opB      = 32'd3;
        @(posedge clock);
        #1;
        ctrlMult = 1'b0;
        rdyCount = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clock);
            #1;
            if (resultRdy) rdyCount++;
            if (e == 5) begin
                ctrlMult = 1'b1;
                opA      = 32'd9;
                opB      = 32'd9;
            end
            if (e == 6) ctrlMult = 1'b0;
            if (e == 16) begin
                ctrlMult = 1'b1;
                opA      = 32'd4;
                opB      = 32'd4;
            end
        end
        @(posedge clock);
        #1;
        ctrlMult = 1'b0;
        checkVal("ovl_early", 64'(rdyCount), 64'd0);
        checkVal("ovl_rdy", 64'(resultRdy), 64'd1);
        checkVal("ovl_res", 64'(result), 64'd6);
        checkVal("ovl_busy", 64'(busy), 64'd1);
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (resultRdy) break;
        end
        checkVal("b2b_lat", 64'(edges), 64'd17);
        checkVal("b2b_res", 64'(result), 64'd16);
        @(posedge clock);
        #1;

        // Reset mid-RUN aborts the operation and clears every output.
        @(negedge clock);
        ctrlMult = 1'b1;
        opA      = 32'd100;
        opB      = 32'd100;
        @(posedge clock);
        #1;
        ctrlMult = 1'b0;
        rdyCount = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock);
            #1;
            if (resultRdy) rdyCount++;
        end
        resetn = 1'b0;
        @(posedge clock);
        #1;
        checkVal("abort_res", 64'(result), 64'd0);
        checkVal("abort_exc", 64'(exception), 64'd0);
        checkVal("abort_busy", 64'(busy), 64'd0);
        checkHi("abort_hi", 32'h0);
        resetn = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock);
            #1;
            if (resultRdy) rdyCount++;
        end
        checkVal("abort_nordy", 64'(rdyCount), 64'd0);

        doMult("m100sq", 32'd100, 32'd100, 32'd10000, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
